fifo_unpack: RTL and testbench

//   Parametrised FIFO-to-register unpacker; next generation of the fixed 12-byte FIFO reader.
//   On a start request it reads a runtime-selected number of WIDTH-bit words from a standard
//   (non-FWFT, 1-cycle read latency) FIFO and packs them into a wide result bus.

---
 rtl/fifo_unpack_if.sv | 27 ++
 rtl/fifo_unpack.sv | 110 +++++++++++
 tb/tb_fifo_unpack.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_unpack_if.sv
// Bundle of the fifo_unpack handshake, FIFO read port and packed-result signals.
// The master side drives the start request and the FIFO outputs. The slave side is the unpacker.
interface fifo_unpack_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  logic                     fs;
  logic [LEN_W-1:0]         data_len;
  logic                     fifo_empty;
  logic [WIDTH-1:0]         din;
  logic                     fifo_rxen;
  logic [WIDTH*MAX_LEN-1:0] res;
  logic [LEN_W-1:0]         rx_cnt;
  logic                     fd;
  logic                     err;

  modport master (
    output fs, data_len, fifo_empty, din,
    input  fifo_rxen, res, rx_cnt, fd, err
  );

  modport slave (
    input  fs, data_len, fifo_empty, din,
    output fifo_rxen, res, rx_cnt, fd, err
  );
endinterface

// File: rtl/fifo_unpack.sv
// Reads data_len words from a standard 1-cycle-latency FIFO and packs them into res.
// It tolerates an empty FIFO, aborts with err after TIMEOUT consecutive stalled cycles, and flags bad lengths.
module fifo_unpack #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_unpack_if.slave  bus
);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0]   MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [LEN_W-1:0]         len;
  logic [LEN_W-1:0]         rd_cnt;
  logic [LEN_W-1:0]         rx_cnt;
  logic                     cap_vld;
  logic [STALL_W-1:0]       stall_cnt;
  logic [WIDTH*MAX_LEN-1:0] res;
  logic                     err;

  logic len_bad;
  logic rxen;
  logic stalled;
  logic timed_out;
  logic last_cap;

  assign len_bad   = (bus.data_len == '0) || (bus.data_len > MAX_LEN_L);
  assign rxen      = (state == READ) && !bus.fifo_empty && (rd_cnt < len);
  assign stalled   = (state == READ) && bus.fifo_empty && (rd_cnt < len);
  assign timed_out = stalled && (stall_cnt == STALL_LAST);
  // The final word is still in flight one cycle after its read, so completion keys off the capture.
  assign last_cap  = cap_vld && (rx_cnt == len - LEN_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.fs) state_nxt = len_bad ? DONE : READ;
      READ:    if (last_cap || timed_out) state_nxt = DONE;
      DONE:    if (!bus.fs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the result bank is plain flops cleared by reset, because consumers rely on res=0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      rd_cnt    <= '0;
      rx_cnt    <= '0;
      cap_vld   <= 1'b0;
      stall_cnt <= '0;
      res       <= '0;
      err       <= 1'b0;
    end else begin
      cap_vld <= rxen;
      unique case (state)
        IDLE: begin
          if (bus.fs) begin
            len       <= bus.data_len;
            rd_cnt    <= '0;
            rx_cnt    <= '0;
            stall_cnt <= '0;
            res       <= '0;
            err       <= len_bad;
          end
        end
        READ: begin
          if (rxen) begin
            rd_cnt    <= rd_cnt + LEN_W'(1);
            stall_cnt <= '0;
          end else if (stalled) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
          if (timed_out) err <= 1'b1;
          if (cap_vld) begin
            for (int k = 0; k < MAX_LEN; k++) begin
              if (rx_cnt == LEN_W'(k)) res[k*WIDTH +: WIDTH] <= bus.din;
            end
            rx_cnt <= rx_cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rxen = rxen;
  assign bus.res       = res;
  assign bus.rx_cnt    = rx_cnt;
  assign bus.fd        = (state == DONE);
  assign bus.err       = err;
endmodule

// File: tb/tb_fifo_unpack.sv
// Self-checking bench for fifo_unpack: it runs directed scenarios and randomized transfers against a queue-based FIFO.
// Expected results come from the transfer rules: the first L pushed words are packed in order, and the bench checks latencies and errors.
module tb_fifo_unpack;
  localparam int W  = 8;
  localparam int ML = 16;
  localparam int LW = 5;
  localparam int TO = 255;
  localparam int RW = W * ML;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_unpack_if #(.WIDTH(W), .MAX_LEN(ML), .LEN_W(LW)) bus ();

  fifo_unpack #(.WIDTH(W), .MAX_LEN(ML), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fifo_q[$];
  int rxen_cnt   = 0;
  int rd_viol    = 0;
  int pop_total  = 0;
  int gap_at     = -1;
  int gap_cycles = 0;
  int gap_left   = 0;
  bit rand_gap   = 1'b0;

  // Standard FIFO: din is valid one cycle after a read, and the registered empty flag can be forced for gaps.
  always @(posedge clk) begin : fifo_model
    if (bus.fifo_rxen) begin
      rxen_cnt <= rxen_cnt + 1;
      if (bus.fifo_empty || fifo_q.size() == 0) rd_viol <= rd_viol + 1;
      if (fifo_q.size() != 0) begin
        bus.din   <= fifo_q.pop_front();
        pop_total <= pop_total + 1;
      end
    end
    if (bus.fifo_rxen && (pop_total + 1 == gap_at)) begin
      gap_left       <= gap_cycles - 1;
      bus.fifo_empty <= 1'b1;
    end else if (gap_left > 0) begin
      gap_left       <= gap_left - 1;
      bus.fifo_empty <= 1'b1;
    end else begin
      bus.fifo_empty <= (fifo_q.size() == 0) || (rand_gap && ($urandom_range(0, 3) == 0));
    end
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic [W-1:0] w[$], input int n);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*W +: W] = w[k];
    return r;
  endfunction

  task automatic start(input int len);
    bus.data_len = LW'(len);
    bus.fs       = 1'b1;
  endtask

  // cyc counts the sample after the start edge as 1. Only the cycles before fd rises add to the rxen and empty stats.
  task automatic wait_fd(input int budget, output int cyc, output int first_rx,
                         output int last_rx, output int n_rx, output int n_emp);
    cyc = 0; first_rx = -1; last_rx = -1; n_rx = 0; n_emp = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.fd === 1'b1) break;
      if (bus.fifo_rxen === 1'b1) begin
        if (first_rx < 0) first_rx = cyc;
        last_rx = cyc;
        n_rx++;
      end
      if (bus.fifo_empty === 1'b1) n_emp++;
      if (cyc >= budget) begin
        check("fd_wait", bus.fd, 1);
        break;
      end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc, f_rx, l_rx, n_rx, n_emp, w, r0, len;
    logic [W-1:0] exp_w[$];
    logic [W-1:0] q2[$];

    rst_n = 1'b0;
    bus.fs = 1'b0;
    bus.data_len = '0;
    repeat (3) @(negedge clk);
    check("rst_rxen",   bus.fifo_rxen, 0);
    check("rst_fd",     bus.fd, 0);
    check("rst_err",    bus.err, 0);
    check("rst_rx_cnt", bus.rx_cnt, 0);
    check("rst_res",    bus.res, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: 12 contiguous words 01..0C
    exp_w.delete();
    for (int k = 0; k < 12; k++) begin
      exp_w.push_back(W'(k + 1));
      fifo_q.push_back(W'(k + 1));
    end
    repeat (2) @(negedge clk);
    start(12);
    wait_fd(100, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t1_fd_cycle", cyc, 14);
    check("t1_first_rx", f_rx, 1);
    check("t1_last_rx",  l_rx, 12);
    check("t1_n_rx",     n_rx, 12);
    check("t1_res",      bus.res, pack(exp_w, 12));
    check("t1_rx_cnt",   bus.rx_cnt, 12);
    check("t1_err",      bus.err, 0);
    bus.fs = 1'b0;
    @(negedge clk);
    check("t1_fd_low",   bus.fd, 0);
    check("t1_res_held", bus.res, pack(exp_w, 12));

    // T2: 16 words with a 5-cycle empty gap after word 4
    exp_w.delete();
    for (int k = 0; k < 16; k++) begin
      w = int'($urandom_range(0, 255));
      exp_w.push_back(W'(w));
      fifo_q.push_back(W'(w));
    end
    gap_at = pop_total + 4;
    gap_cycles = 5;
    repeat (2) @(negedge clk);
    start(16);
    wait_fd(200, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t2_fd_cycle", cyc, 16 + 2 + 5);
    check("t2_first_rx", f_rx, 1);
    check("t2_last_rx",  l_rx, 16 + 5);
    check("t2_n_rx",     n_rx, 16);
    check("t2_res",      bus.res, pack(exp_w, 16));
    check("t2_rx_cnt",   bus.rx_cnt, 16);
    check("t2_err",      bus.err, 0);
    gap_at = -1;
    bus.fs = 1'b0;
    @(negedge clk);

    // T3: 3 of 8 words available, so the transfer times out
    exp_w.delete();
    for (int k = 0; k < 3; k++) begin
      exp_w.push_back(W'(8'h30 + k));
      fifo_q.push_back(W'(8'h30 + k));
    end
    repeat (2) @(negedge clk);
    start(8);
    wait_fd(400, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t3_empty_cycles", n_emp, TO);
    check("t3_fd_cycle",     cyc, 3 + 1 + TO);
    check("t3_n_rx",         n_rx, 3);
    check("t3_err",          bus.err, 1);
    check("t3_rx_cnt",       bus.rx_cnt, 3);
    check("t3_res",          bus.res, pack(exp_w, 3));
    bus.fs = 1'b0;
    @(negedge clk);
    check("t3_fd_low",       bus.fd, 0);
    check("t3_err_held",     bus.err, 1);
    check("t3_rx_cnt_held",  bus.rx_cnt, 3);

    // T4: illegal lengths 0 and 17
    r0 = rxen_cnt;
    start(0);
    wait_fd(10, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t4_len0_fd_cycle", cyc, 1);
    check("t4_len0_err",      bus.err, 1);
    check("t4_len0_res",      bus.res, 0);
    check("t4_len0_rx_cnt",   bus.rx_cnt, 0);
    bus.fs = 1'b0;
    @(negedge clk);
    check("t4_len0_fd_low",   bus.fd, 0);
    start(17);
    wait_fd(10, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t4_len17_fd_cycle", cyc, 1);
    check("t4_len17_err",      bus.err, 1);
    check("t4_len17_res",      bus.res, 0);
    check("t4_no_rxen",        rxen_cnt - r0, 0);
    bus.fs = 1'b0;
    @(negedge clk);

    // T6: fs dropped at word 2 of 6, then a back-to-back 3-word transfer
    exp_w.delete();
    for (int k = 0; k < 9; k++) begin
      w = int'($urandom_range(1, 255));
      exp_w.push_back(W'(w));
      fifo_q.push_back(W'(w));
    end
    repeat (2) @(negedge clk);
    start(6);
    @(negedge clk);
    check("t6_err_cleared", bus.err, 0);
    check("t6_res_cleared", bus.res, 0);
    for (int i = 0; i < 50 && bus.rx_cnt != LW'(2); i++) @(negedge clk);
    check("t6_reach_word2", bus.rx_cnt, 2);
    bus.fs = 1'b0;
    wait_fd(50, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t6_rx_cnt", bus.rx_cnt, 6);
    check("t6_res",    bus.res, pack(exp_w, 6));
    check("t6_err",    bus.err, 0);
    w = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.fd === 1'b1) w++;
      else break;
    end
    check("t6_fd_width", w, 1);
    q2.delete();
    for (int k = 6; k < 9; k++) q2.push_back(exp_w[k]);
    start(3);
    wait_fd(50, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t6_b2b_res",    bus.res, pack(q2, 3));
    check("t6_b2b_rx_cnt", bus.rx_cnt, 3);
    check("t6_b2b_err",    bus.err, 0);
    bus.fs = 1'b0;
    @(negedge clk);

    // T5: reset in the middle of a 10-word transfer, then a clean restart
    exp_w.delete();
    for (int k = 0; k < 10; k++) begin
      exp_w.push_back(W'(8'h50 + k));
      fifo_q.push_back(W'(8'h50 + k));
    end
    repeat (2) @(negedge clk);
    start(10);
    for (int i = 0; i < 50 && bus.rx_cnt != LW'(5); i++) @(negedge clk);
    check("t5_reach_word5", bus.rx_cnt, 5);
    rst_n = 1'b0;
    bus.fs = 1'b0;
    #1;
    check("t5_rst_rxen",   bus.fifo_rxen, 0);
    check("t5_rst_fd",     bus.fd, 0);
    check("t5_rst_err",    bus.err, 0);
    check("t5_rst_rx_cnt", bus.rx_cnt, 0);
    check("t5_rst_res",    bus.res, 0);
    @(negedge clk);
    fifo_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_w.delete();
    for (int k = 0; k < 4; k++) begin
      exp_w.push_back(W'(8'hC0 + k));
      fifo_q.push_back(W'(8'hC0 + k));
    end
    repeat (2) @(negedge clk);
    start(4);
    wait_fd(50, cyc, f_rx, l_rx, n_rx, n_emp);
    check("t5_restart_fd_cycle", cyc, 4 + 2);
    check("t5_restart_res",      bus.res, pack(exp_w, 4));
    check("t5_restart_rx_cnt",   bus.rx_cnt, 4);
    check("t5_restart_err",      bus.err, 0);
    bus.fs = 1'b0;
    @(negedge clk);

    // Randomized transfers with random single-cycle empty gaps and occasional illegal lengths
    rand_gap = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) begin
        len = (i % 8 == 3) ? 0 : int'($urandom_range(17, 31));
        r0 = rxen_cnt;
        start(len);
        wait_fd(10, cyc, f_rx, l_rx, n_rx, n_emp);
        check("rnd_bad_err",    bus.err, 1);
        check("rnd_bad_res",    bus.res, 0);
        check("rnd_bad_rx_cnt", bus.rx_cnt, 0);
        check("rnd_bad_rxen",   rxen_cnt - r0, 0);
      end else begin
        len = int'($urandom_range(1, ML));
        exp_w.delete();
        for (int k = 0; k < len; k++) begin
          w = int'($urandom_range(0, 255));
          exp_w.push_back(W'(w));
          fifo_q.push_back(W'(w));
        end
        @(negedge clk);
        start(len);
        wait_fd(400, cyc, f_rx, l_rx, n_rx, n_emp);
        check("rnd_rx_cnt", bus.rx_cnt, len);
        check("rnd_err",    bus.err, 0);
        check("rnd_res",    bus.res, pack(exp_w, len));
        check("rnd_n_rx",   n_rx, len);
      end
      bus.fs = 1'b0;
      @(negedge clk);
      check("rnd_fd_low", bus.fd, 0);
    end
    rand_gap = 1'b0;
    repeat (2) @(negedge clk);

    check("rxen_while_empty", rd_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
